// File: rtl/friet_permutation_protected_core.sv
// Friet-PC permutation core: one protected round per cycle over a 4-limb state (d = a^b^c check limb).
// Optional limb-invariant checker enabled by the FRIET_FAULT_CHECK_EN macro.

module friet_permutation_protected_round (
  input  logic [127:0] a,
  input  logic [127:0] b,
  input  logic [127:0] c,
  input  logic [127:0] d,
  input  logic [4:0]   rc_c,
  input  logic [4:0]   rc_d,
  output logic [127:0] a_next,
  output logic [127:0] b_next,
  output logic [127:0] c_next,
  output logic [127:0] d_next
);

  function automatic logic [127:0] rotl(input logic [127:0] x, input int unsigned n);
    return (x << n) | (x >> (128 - n));
  endfunction

  logic [127:0] c_rc, d_rc;
  logic [127:0] mix1, mix2, b_mu1, d_mu1, c_mu2, d_mu2, prod;

  // Every step adds the same term to d as to one working limb, so a^b^c^d is invariant.
  assign c_rc  = c ^ {123'd0, rc_c};
  assign d_rc  = d ^ {123'd0, rc_d};

  // tau1 (a,b,c,d) <- (d, c, a, b), then mu1 and mu2
  assign mix1  = rotl(a, 1);
  assign b_mu1 = c_rc ^ mix1;
  assign d_mu1 = b ^ mix1;
  assign mix2  = rotl(b_mu1, 80);
  assign c_mu2 = a ^ mix2;
  assign d_mu2 = d_mu1 ^ mix2;

  // tau2 swaps b and d; xi is the only nonlinear step
  assign prod   = rotl(d_mu2, 36) & rotl(c_mu2, 67);
  assign a_next = d_rc ^ prod;
  assign b_next = d_mu2;
  assign c_next = c_mu2;
  assign d_next = b_mu1 ^ prod;

endmodule

module friet_permutation_protected_core #(
  parameter int NUM_ROUNDS = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic [127:0] din_a,
  input  logic [127:0] din_b,
  input  logic [127:0] din_c,
  input  logic [127:0] din_d,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic [127:0] dout_a,
  output logic [127:0] dout_b,
  output logic [127:0] dout_c,
  output logic [127:0] dout_d,
  output logic         fault_error
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         fsm;
  logic [127:0] a, b, c, d;
  logic [127:0] a_next, b_next, c_next, d_next;
  logic [4:0]   round_cnt;
  logic [3:0]   lfsr;
  logic [4:0]   rc_c, rc_d;
  logic         last_round;

  assign rc_c       = {round_cnt[0], lfsr};
  assign rc_d       = {round_cnt[0], lfsr};
  assign last_round = (round_cnt == 5'(NUM_ROUNDS - 1));

  friet_permutation_protected_round u_round (
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .rc_c   (rc_c),
    .rc_d   (rc_d),
    .a_next (a_next),
    .b_next (b_next),
    .c_next (c_next),
    .d_next (d_next)
  );

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= IDLE;
      a          <= '0;
      b          <= '0;
      c          <= '0;
      d          <= '0;
      round_cnt  <= '0;
      lfsr       <= 4'hF;
      din_ready  <= 1'b1;
      dout_valid <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (din_valid) begin
            a         <= din_a;
            b         <= din_b;
            c         <= din_c;
            d         <= din_d;
            round_cnt <= '0;
            lfsr      <= 4'hF;
            din_ready <= 1'b0;
            fsm       <= RUN;
          end
        end
        RUN: begin
          a         <= a_next;
          b         <= b_next;
          c         <= c_next;
          d         <= d_next;
          round_cnt <= round_cnt + 5'd1;
          lfsr      <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
          if (last_round) begin
            dout_valid <= 1'b1;
            fsm        <= DONE;
          end
        end
        DONE: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            din_ready  <= 1'b1;
            fsm        <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign dout_a = a;
  assign dout_b = b;
  assign dout_c = c;
  assign dout_d = d;

`ifdef FRIET_FAULT_CHECK_EN
  logic fault_q;
  logic done_entry;
  logic check_en;
  logic limb_nz;

  assign limb_nz     = |(a ^ b ^ c ^ d);
  assign check_en    = (fsm == RUN) || ((fsm == DONE) && done_entry);
  // The live term flags a violation in the very cycle it is observed; fault_q makes it sticky.
  assign fault_error = fault_q | (check_en & limb_nz);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q    <= 1'b0;
      done_entry <= 1'b0;
    end else begin
      done_entry <= (fsm == RUN) && last_round;
      if ((fsm == IDLE) && din_valid) begin
        fault_q <= 1'b0;
      end else if (check_en && limb_nz) begin
        fault_q <= 1'b1;
      end
    end
  end
`else
  assign fault_error = 1'b0;
`endif

endmodule

// File: tb/tb_friet_permutation_protected_core.sv
// Self-checking bench for friet_permutation_protected_core against a tuple-level Friet-PC model.
// Fault expectations follow FRIET_FAULT_CHECK_EN when the bench is compiled with it.

module tb_friet_permutation_protected_core;

  localparam int N = 24;

`ifdef FRIET_FAULT_CHECK_EN
  localparam logic FAULT_EXP = 1'b1;
`else
  localparam logic FAULT_EXP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [127:0] din_a = '0, din_b = '0, din_c = '0, din_d = '0;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic [127:0] dout_a, dout_b, dout_c, dout_d;
  logic         fault_error;

  int checks = 0;
  int failures = 0;

  friet_permutation_protected_core #(.NUM_ROUNDS(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .din_a       (din_a),
    .din_b       (din_b),
    .din_c       (din_c),
    .din_d       (din_d),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_a      (dout_a),
    .dout_b      (dout_b),
    .dout_c      (dout_c),
    .dout_d      (dout_d),
    .fault_error (fault_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rotl(input logic [127:0] x, input int n);
    return (x << n) | (x >> (128 - n));
  endfunction

  // Reference: the Friet-PC round applied as successive tuple updates on (a,b,c,d).
  function automatic logic [511:0] model(input logic [127:0] a0, b0, c0, d0);
    logic [127:0] a, b, c, d, t;
    logic [3:0]   lf;
    logic [4:0]   rc;
    a = a0; b = b0; c = c0; d = d0;
    lf = 4'hF;
    for (int r = 0; r < N; r++) begin
      rc = {r[0], lf};
      c = c ^ 128'(rc);
      d = d ^ 128'(rc);
      {a, b, c, d} = {d, c, a, b};
      t = rotl(c, 1);  b = b ^ t; d = d ^ t;
      t = rotl(b, 80); c = c ^ t; d = d ^ t;
      {b, d} = {d, b};
      t = rotl(b, 36) & rotl(c, 67);
      a = a ^ t; d = d ^ t;
      lf = {lf[2:0], lf[3] ^ lf[2]};
    end
    return {a, b, c, d};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic accept(input logic [127:0] a, b, c, d);
    int n = 0;
    while (!din_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 512'(din_ready), 512'(1));
    din_a = a; din_b = b; din_c = c; din_d = d;
    din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // Waits from the first negedge after acceptance; lat counts edges since acceptance.
  task automatic wait_done(input bit noise, input bit fault_probe, input logic fault_exp, output int lat);
    lat = 0;
    while (!dout_valid && lat < 100) begin
      if (fault_probe) chk($sformatf("fault_run_%0d", lat), 512'(fault_error), 512'(fault_exp));
      if (noise) begin
        din_valid = 1'($urandom);
        din_a = rand128(); din_b = rand128(); din_c = rand128(); din_d = rand128();
      end
      @(negedge clk);
      lat++;
    end
    din_valid = 1'b0;
  endtask

  task automatic handshake();
    dout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dout_ready = 1'b0;
    chk("post_hs_dout_valid", 512'(dout_valid), 512'(0));
    chk("post_hs_din_ready", 512'(din_ready), 512'(1));
  endtask

  logic [127:0] ra, rb, rc, rd;
  logic [511:0] exp_s, held;
  int           lat;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_din_ready", 512'(din_ready), 512'(1));
    chk("rst_dout_valid", 512'(dout_valid), 512'(0));
    chk("rst_dout", {dout_a, dout_b, dout_c, dout_d}, 512'(0));
    chk("rst_fault", 512'(fault_error), 512'(0));
    rst = 1'b0;
    @(negedge clk);

    // All-zero state, dout_ready held high; probe round constants for rounds 0..2
    dout_ready = 1'b1;
    accept('0, '0, '0, '0);
    chk("rc_r0", 512'(dut.rc_c), 512'(5'h0F));
    chk("rc_eq_r0", 512'(dut.rc_d), 512'(dut.rc_c));
    @(negedge clk);
    chk("rc_r1", 512'(dut.rc_c), 512'(5'h1E));
    chk("rc_eq_r1", 512'(dut.rc_d), 512'(dut.rc_c));
    @(negedge clk);
    chk("rc_r2", 512'(dut.rc_c), 512'(5'h0C));
    chk("rc_eq_r2", 512'(dut.rc_d), 512'(dut.rc_c));
    for (int r = 3; r < N; r++) begin
      @(negedge clk);
      chk($sformatf("rc_eq_r%0d", r), 512'(dut.rc_d), 512'(dut.rc_c));
      chk($sformatf("din_ready_run_r%0d", r), 512'(din_ready), 512'(0));
    end
    @(negedge clk);
    chk("zero_latency_valid", 512'(dout_valid), 512'(1));
    chk("zero_result", {dout_a, dout_b, dout_c, dout_d}, model('0, '0, '0, '0));
    chk("zero_fault", 512'(fault_error), 512'(0));
    @(negedge clk);
    chk("zero_auto_hs", 512'(din_ready), 512'(1));
    dout_ready = 1'b0;

    // Random consistent states with din noise during RUN
    for (int i = 0; i < 4; i++) begin
      ra = rand128(); rb = rand128(); rc = rand128(); rd = ra ^ rb ^ rc;
      exp_s = model(ra, rb, rc, rd);
      accept(ra, rb, rc, rd);
      wait_done(1'b1, 1'b0, 1'b0, lat);
      chk($sformatf("rand%0d_latency", i), 512'(lat), 512'(N));
      chk($sformatf("rand%0d_result", i), {dout_a, dout_b, dout_c, dout_d}, exp_s);
      chk($sformatf("rand%0d_invariant", i), 512'(dout_a ^ dout_b ^ dout_c ^ dout_d), 512'(0));
      chk($sformatf("rand%0d_fault", i), 512'(fault_error), 512'(0));
      handshake();
    end

    // Broken invariant: d=1 with a=b=c=0
    exp_s = model('0, '0, '0, 128'h1);
    accept('0, '0, '0, 128'h1);
    wait_done(1'b0, 1'b1, FAULT_EXP, lat);
    chk("inj_result", {dout_a, dout_b, dout_c, dout_d}, exp_s);
    chk("inj_fault_done", 512'(fault_error), 512'(FAULT_EXP));
    @(negedge clk);
    chk("inj_fault_done_hold", 512'(fault_error), 512'(FAULT_EXP));
    handshake();
    chk("inj_fault_idle_sticky", 512'(fault_error), 512'(FAULT_EXP));
    accept('0, '0, '0, '0);
    chk("inj_fault_cleared", 512'(fault_error), 512'(0));
    wait_done(1'b0, 1'b0, 1'b0, lat);
    chk("clean_after_inj_fault", 512'(fault_error), 512'(0));
    handshake();

    // DONE back-pressure while din_valid toggles
    ra = rand128(); rb = rand128(); rc = rand128(); rd = ra ^ rb ^ rc;
    exp_s = model(ra, rb, rc, rd);
    accept(ra, rb, rc, rd);
    wait_done(1'b0, 1'b0, 1'b0, lat);
    held = {dout_a, dout_b, dout_c, dout_d};
    chk("bp_result", held, exp_s);
    ra = rand128(); rb = rand128(); rc = rand128(); rd = ra ^ rb ^ rc;
    din_a = ra; din_b = rb; din_c = rc; din_d = rd;
    for (int k = 0; k < 10; k++) begin
      din_valid = ~din_valid;
      @(negedge clk);
      chk($sformatf("bp_stable_%0d", k), {dout_a, dout_b, dout_c, dout_d}, held);
      chk($sformatf("bp_din_ready_%0d", k), 512'(din_ready), 512'(0));
      chk($sformatf("bp_valid_%0d", k), 512'(dout_valid), 512'(1));
    end
    din_valid = 1'b1;
    dout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dout_ready = 1'b0;
    chk("bp_not_accepted_in_hs", 512'(din_ready), 512'(1));
    chk("bp_output_kept_after_hs", {dout_a, dout_b, dout_c, dout_d}, held);
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
    chk("bp_second_accepted", 512'(din_ready), 512'(0));
    wait_done(1'b0, 1'b0, 1'b0, lat);
    chk("bp_second_latency", 512'(lat), 512'(N));
    chk("bp_second_result", {dout_a, dout_b, dout_c, dout_d}, model(ra, rb, rc, rd));
    handshake();

    // Reset at round 10, then a fresh permutation
    accept(rand128(), rand128(), rand128(), rand128());
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_din_ready", 512'(din_ready), 512'(1));
    chk("abort_dout_valid", 512'(dout_valid), 512'(0));
    chk("abort_dout", {dout_a, dout_b, dout_c, dout_d}, 512'(0));
    chk("abort_fault", 512'(fault_error), 512'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle_hold", 512'(din_ready), 512'(1));
    ra = rand128(); rb = rand128(); rc = rand128(); rd = ra ^ rb ^ rc;
    accept(ra, rb, rc, rd);
    wait_done(1'b0, 1'b0, 1'b0, lat);
    chk("fresh_latency", 512'(lat), 512'(N));
    chk("fresh_result", {dout_a, dout_b, dout_c, dout_d}, model(ra, rb, rc, rd));
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
